// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM that sequences a shared-memory datapath
// through 3-5 cycles per instruction. Only pcen depends on a live input (zero).
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StAluWb   = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11
    } state_e;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e r_state;
    state_e w_next;
    logic   w_pcwrite;
    logic   w_branch;
    logic   w_memwrite;
    logic   w_irwrite;
    logic   w_regwrite;
    logic [2:0] w_funct_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_funct_alu = 3'b010;
        case (funct)
            6'b100000: w_funct_alu = 3'b010;
            6'b100010: w_funct_alu = 3'b110;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b111;
            default:   w_funct_alu = 3'b010;
        endcase
    end

    always_comb begin
        w_next     = StFetch;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        case (r_state)
            StFetch: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
                w_next    = StDecode;
            end
            StDecode: begin
                alusrcb = 2'b11;
                case (op)
                    OpLw, OpSw: w_next = StMemAdr;
                    OpRtype:    w_next = StRtypeEx;
                    OpBeq:      w_next = StBeqEx;
                    OpAddi:     w_next = StAddiEx;
                    OpJ:        w_next = StJEx;
                    default:    w_next = StFetch;
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord   = 1'b1;
                w_next = StMemWb;
            end
            StMemWb: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            StMemWr: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca    = 1'b1;
                alucontrol = w_funct_alu;
                w_next     = StAluWb;
            end
            StAluWb: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            StBeqEx: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = StAddiWb;
            end
            StAddiWb: begin
                w_regwrite = 1'b1;
            end
            StJEx: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = StFetch;
        endcase
    end

    // Reset masks the enables so FETCH cannot write while held in reset.
    assign pcen     = ~reset & (w_pcwrite | (w_branch & zero));
    assign memwrite = ~reset & w_memwrite;
    assign irwrite  = ~reset & w_irwrite;
    assign regwrite = ~reset & w_regwrite;
    assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: instruction-level path model pushes expected
// per-cycle outputs; a negedge monitor pops and compares.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'b000000;
    logic [5:0] funct = 6'b100000;
    logic       zero = 1'b0;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int total = 0;
    int bad = 0;
    logic [18:0] sb_q[$];
    logic [18:0] mon_exp;
    logic [18:0] obs;
    int path[$];

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                  alusrca, alusrcb, pcsrc, alucontrol};

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for a named step of an instruction, taken from the state table.
    function automatic logic [18:0] model(input int st, input logic [5:0] f,
                                          input logic z, input logic rst);
        logic [3:0] s4;
        logic pw, br, mw, irw, rw, io, m2r, rd, asa;
        logic [1:0] asb, pcs;
        logic [2:0] aluc;
        int s;
        s = rst ? 0 : st;
        s4 = s[3:0];
        pw = 0; br = 0; mw = 0; irw = 0; rw = 0; io = 0; m2r = 0; rd = 0; asa = 0;
        asb = 2'b00; pcs = 2'b00; aluc = 3'b010;
        case (s)
            0:  begin irw = 1; pw = 1; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin asa = 1; aluc = ref_alu(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aluc = 3'b110; pcs = 2'b01; br = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pw = 1; end
            default: ;
        endcase
        if (rst) begin
            pw = 0; br = 0; irw = 0;
        end
        return {s4, pw | (br & z), mw, irw, rw, io, m2r, rd, asa, asb, pcs, aluc};
    endfunction

    task automatic build_path(input logic [5:0] o);
        case (o)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
            6'b001000: path = '{0, 1, 9, 10};
            6'b000010: path = '{0, 1, 11};
            default:   path = '{0, 1};
        endcase
    endtask

    task automatic step(input int st, input int zmode);
        zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
        sb_q.push_back(model(st, funct, zero, 1'b0));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        op = o;
        funct = f;
        build_path(o);
        foreach (path[i]) step(path[i], (path[i] == 8) ? zmode : -1);
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            zero = 1'($urandom_range(0, 1));
            sb_q.push_back(model(0, funct, zero, 1'b1));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            total++;
            if (obs !== mon_exp) begin
                bad++;
                $display("FAIL outputs t=%0t got=%b exp=%b (state pcen mw irw rw iord m2r rd asa asb pcs alu)",
                         $time, obs, mon_exp);
            end
        end
    end

    logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        hold_reset(3);

        run_instr(6'b000000, 6'b100000, -1);
        run_instr(6'b100011, 6'b100000, -1);
        run_instr(6'b101011, 6'b100000, -1);
        run_instr(6'b000100, 6'b100000, 1);
        run_instr(6'b000100, 6'b100000, 0);
        foreach (fns[i]) run_instr(6'b000000, fns[i], -1);
        run_instr(6'b001000, 6'b000000, -1);
        run_instr(6'b000010, 6'b000000, -1);
        run_instr(6'b111111, 6'b000000, -1);

        // Abandon a lw in MEMRD: state must fall to FETCH without waiting for a clock.
        op = 6'b100011;
        step(0, -1);
        step(1, -1);
        step(2, -1);
        zero = 1'b0;
        sb_q.push_back(model(3, funct, zero, 1'b0));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || regwrite !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got state=%0d regwrite=%b exp state=0 regwrite=0",
                     state, regwrite);
        end
        @(posedge clk);
        #1;
        hold_reset(2);

        repeat (150) begin
            int k;
            k = $urandom_range(0, 7);
            o = (k < 6) ? ops[k] : 6'($urandom);
            k = $urandom_range(0, 6);
            f = (k < 6) ? fns[k] : 6'($urandom);
            run_instr(o, f, -1);
        end

        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0 pending entries", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
